sysarr_row_dbuf: RTL and testbench

- Next-generation parametrised systolic-array row: ROW_WIDTH multiply-accumulate PEs with configurable data and accumulator widths.
- Adds an explicit valid handshake and a synchronous reset.
- Adds double-buffered weights: a shadow set is streamed in serially while the active set computes, then swapped in atomically once the pipeline drains.
- Rows stack vertically in the array; sum outputs feed the sum inputs of the row below.

---
 rtl/sysarr_pkg.sv | 17 +
 rtl/sysarr_pe_v2.sv | 77 +++++++
 rtl/sysarr_row_dbuf.sv | 173 +++++++++++++++++
 tb/tb_sysarr_row_dbuf.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarr_pkg.sv
// Shared definitions for the double-buffered systolic-array row.
// Holds the weight-loader state encoding and default width constants.
package sysarr_pkg;

  localparam int DEF_ROW_WIDTH = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ACC_W     = 32;

  typedef enum logic [2:0] {
    EMPTY,
    LOADING,
    FULL,
    SWAP_WAIT,
    SWAP
  } wstate_e;

endpackage

// File: rtl/sysarr_pe_v2.sv
// One registered multiply-accumulate PE with valid pass-through.
// Optional SYSARR_SAT_EN clamps the accumulate instead of wrapping.
module sysarr_pe_v2
  import sysarr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] weight,
  input  logic [ACC_W-1:0]  sum_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
`ifdef SYSARR_SAT_EN
  output logic              sat_hit,
`endif
  output logic [ACC_W-1:0]  out_sum
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ACC_W-1:0]  sum_q, sum_d;

  logic signed [2*DATA_W-1:0] a_ext, w_ext, prod;
  logic signed [ACC_W:0]      prod_ext, sum_ext, wide;
  logic                       ovf;

  // One guard bit above ACC_W exposes signed overflow of the accumulate.
  always_comb begin
    a_ext    = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    w_ext    = {{DATA_W{weight[DATA_W-1]}}, weight};
    prod     = a_ext * w_ext;
    prod_ext = {{(ACC_W + 1 - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    sum_ext  = {sum_in[ACC_W-1], sum_in};
    wide     = prod_ext + sum_ext;
    ovf      = wide[ACC_W] ^ wide[ACC_W-1];
  end

  always_comb begin
    valid_d = in_valid;
    data_d  = data_q;
    sum_d   = sum_q;
    if (in_valid) begin
      data_d = in_data;
      sum_d  = wide[ACC_W-1:0];
`ifdef SYSARR_SAT_EN
      if (ovf) begin
        sum_d = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`endif
    end
  end

`ifdef SYSARR_SAT_EN
  assign sat_hit = in_valid & ovf;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sum   = sum_q;

endmodule

// File: rtl/sysarr_row_dbuf.sv
// Systolic-array row with serially loaded shadow weights swapped in once the pipe drains.
// Define SYSARR_SAT_EN for saturating accumulates and the sticky sat_flag output.
module sysarr_row_dbuf
  import sysarr_pkg::*;
#(
  parameter int ROW_WIDTH = DEF_ROW_WIDTH,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ROW_WIDTH*ACC_W-1:0] sum_in,
  input  logic                       w_wr_valid,
  input  logic [DATA_W-1:0]          w_wr_data,
  output logic                       w_wr_ready,
  input  logic                       w_swap,
  output logic                       weights_valid,
  output logic                       swap_pending,
  output logic [ROW_WIDTH*ACC_W-1:0] macc_out,
  output logic [ROW_WIDTH-1:0]       macc_valid,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_out_valid,
`ifdef SYSARR_SAT_EN
  output logic                       sat_flag,
`endif
  output logic                       drop_err
);

  localparam int CNT_W = $clog2(ROW_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_WIDTH - 1);

  wstate_e           state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q [ROW_WIDTH];
  logic [DATA_W-1:0] shadow_d [ROW_WIDTH];
  logic [DATA_W-1:0] active_q [ROW_WIDTH];
  logic [DATA_W-1:0] active_d [ROW_WIDTH];
  logic              weights_valid_q, weights_valid_d;
  logic              drop_err_q, drop_err_d;

  logic [ROW_WIDTH-1:0] pe_valid;
  logic [DATA_W-1:0]    pe_data [ROW_WIDTH];
  logic [ACC_W-1:0]     pe_sum  [ROW_WIDTH];
  logic                 head_valid;
  logic                 pipe_empty;

  // Tokens arriving before any weight set is active never enter the pipe.
  assign head_valid = in_valid & weights_valid_q;
  assign pipe_empty = (pe_valid == '0) && !in_valid;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    shadow_d        = shadow_q;
    active_d        = active_q;
    weights_valid_d = weights_valid_q;
    drop_err_d      = drop_err_q | (in_valid & ~weights_valid_q);
    w_wr_ready      = 1'b0;
    swap_pending    = 1'b0;
    case (state_q)
      EMPTY: begin
        w_wr_ready = 1'b1;
        if (w_wr_valid) begin
          shadow_d[0] = w_wr_data;
          cnt_d       = CNT_W'(1);
          state_d     = LOADING;
        end
      end
      LOADING: begin
        w_wr_ready = 1'b1;
        if (w_wr_valid) begin
          shadow_d[cnt_q] = w_wr_data;
          if (cnt_q == LAST_IDX) begin
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (w_swap) begin
          state_d = pipe_empty ? SWAP : SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        swap_pending = 1'b1;
        if (pipe_empty) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        active_d        = shadow_q;
        weights_valid_d = 1'b1;
        cnt_d           = '0;
        state_d         = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= EMPTY;
      cnt_q           <= '0;
      shadow_q        <= '{default: '0};
      active_q        <= '{default: '0};
      weights_valid_q <= 1'b0;
      drop_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shadow_q        <= shadow_d;
      active_q        <= active_d;
      weights_valid_q <= weights_valid_d;
      drop_err_q      <= drop_err_d;
    end
  end

`ifdef SYSARR_SAT_EN
  logic [ROW_WIDTH-1:0] sat_hits;
  logic                 sat_flag_q, sat_flag_d;

  always_comb sat_flag_d = sat_flag_q | (|sat_hits);

  always_ff @(posedge clock) begin
    if (reset) sat_flag_q <= 1'b0;
    else       sat_flag_q <= sat_flag_d;
  end

  assign sat_flag = sat_flag_q;
`endif

  for (genvar g = 0; g < ROW_WIDTH; g++) begin : g_pe
    logic              v_in;
    logic [DATA_W-1:0] d_in;
    if (g == 0) begin : g_head
      assign v_in = head_valid;
      assign d_in = in_data;
    end else begin : g_body
      assign v_in = pe_valid[g-1];
      assign d_in = pe_data[g-1];
    end

    sysarr_pe_v2 #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_pe (
      .clock    (clock),
      .reset    (reset),
      .in_valid (v_in),
      .in_data  (d_in),
      .weight   (active_q[g]),
      .sum_in   (sum_in[g*ACC_W +: ACC_W]),
      .out_valid(pe_valid[g]),
      .out_data (pe_data[g]),
`ifdef SYSARR_SAT_EN
      .sat_hit  (sat_hits[g]),
`endif
      .out_sum  (pe_sum[g])
    );

    assign macc_out[g*ACC_W +: ACC_W] = pe_sum[g];
  end

  assign macc_valid     = pe_valid;
  assign data_out       = pe_data[ROW_WIDTH-1];
  assign data_out_valid = pe_valid[ROW_WIDTH-1];
  assign weights_valid  = weights_valid_q;
  assign drop_err       = drop_err_q;

endmodule

// File: tb/tb_sysarr_row_dbuf.sv
// Self-checking bench for sysarr_row_dbuf: directed scenarios plus random traffic
// checked every cycle against a token/weight-snapshot reference model.
module tb_sysarr_row_dbuf;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int HMAX = 4096;

  logic            clock;
  logic            reset;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic [N*AW-1:0] sum_in;
  logic            w_wr_valid;
  logic [DW-1:0]   w_wr_data;
  logic            w_wr_ready;
  logic            w_swap;
  logic            weights_valid;
  logic            swap_pending;
  logic [N*AW-1:0] macc_out;
  logic [N-1:0]    macc_valid;
  logic [DW-1:0]   data_out;
  logic            data_out_valid;
  logic            drop_err;
`ifdef SYSARR_SAT_EN
  logic            sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  sysarr_row_dbuf #(.ROW_WIDTH(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .sum_in        (sum_in),
    .w_wr_valid    (w_wr_valid),
    .w_wr_data     (w_wr_data),
    .w_wr_ready    (w_wr_ready),
    .w_swap        (w_swap),
    .weights_valid (weights_valid),
    .swap_pending  (swap_pending),
    .macc_out      (macc_out),
    .macc_valid    (macc_valid),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
`ifdef SYSARR_SAT_EN
    .sat_flag      (sat_flag),
`endif
    .drop_err      (drop_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: weight sets as whole lists, tokens as history entries
  // carrying the weight snapshot that was active when they entered.
  bit                 m_wv, m_pend, m_swapping, m_drop, m_sat;
  logic signed [7:0]  m_active [N];
  logic signed [7:0]  m_sh [$];
  bit                 h_valid [HMAX];
  logic signed [7:0]  h_data  [HMAX];
  logic signed [7:0]  h_w     [HMAX][N];
  int                 cyc;
  bit                 e_mv [N];
  logic [31:0]        e_sum [N];
  logic [7:0]         e_dout;
  bit                 e_dv;

  function automatic logic [31:0] mac(input logic signed [7:0] w, input logic signed [7:0] d,
                                      input logic [31:0] s, output bit clamped);
    longint r;
    r = longint'(w) * longint'(d) + longint'($signed(s));
    clamped = 1'b0;
`ifdef SYSARR_SAT_EN
    if (r > 64'sd2147483647) begin r = 64'sd2147483647; clamped = 1'b1; end
    if (r < -64'sd2147483648) begin r = -64'sd2147483648; clamped = 1'b1; end
`endif
    return r[31:0];
  endfunction

  task automatic model_reset();
    m_wv = 0; m_pend = 0; m_swapping = 0; m_drop = 0; m_sat = 0;
    m_sh.delete();
    cyc = 0;
    e_dout = '0; e_dv = 0;
    for (int i = 0; i < N; i++) begin
      m_active[i] = '0; e_mv[i] = 0; e_sum[i] = '0;
    end
  endtask

  task automatic model_edge(input bit rst, input bit iv, input logic [7:0] id, input bit wv,
                            input logic [7:0] wd, input bit sw, input logic [N*AW-1:0] si);
    bit inflight, empty, cl;
    int t;
    if (rst) begin
      model_reset();
      return;
    end
    inflight = 0;
    for (int k = 1; k <= N; k++)
      if (cyc - k >= 0 && h_valid[cyc-k]) inflight = 1;
    empty = !inflight && !iv;
    h_valid[cyc] = iv && m_wv;
    h_data[cyc]  = id;
    h_w[cyc]     = m_active;
    if (iv && !m_wv) m_drop = 1;
    for (int i = 0; i < N; i++) begin
      t = cyc - i;
      e_mv[i] = (t >= 0) && h_valid[t];
      if (e_mv[i]) begin
        e_sum[i] = mac(h_w[t][i], h_data[t], si[i*AW +: AW], cl);
        if (cl) m_sat = 1;
      end
    end
    t = cyc - (N - 1);
    e_dv = (t >= 0) && h_valid[t];
    if (e_dv) e_dout = h_data[t];
    if (m_swapping) begin
      for (int i = 0; i < N; i++) m_active[i] = m_sh[i];
      m_sh.delete();
      m_wv = 1;
      m_swapping = 0;
    end else if (m_pend) begin
      if (empty) begin m_pend = 0; m_swapping = 1; end
    end else if (m_sh.size() == N) begin
      if (sw) begin
        if (empty) m_swapping = 1;
        else       m_pend = 1;
      end
    end else if (wv) begin
      m_sh.push_back(wd);
    end
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check_output($sformatf("macc_valid%0d", i), 64'(macc_valid[i]), 64'(e_mv[i]));
      check_output($sformatf("macc_out%0d", i), 64'(macc_out[i*AW +: AW]), 64'(e_sum[i]));
    end
    check_output("data_out_valid", 64'(data_out_valid), 64'(e_dv));
    check_output("data_out", 64'(data_out), 64'(e_dout));
    check_output("weights_valid", 64'(weights_valid), 64'(m_wv));
    check_output("drop_err", 64'(drop_err), 64'(m_drop));
    check_output("w_wr_ready", 64'(w_wr_ready), 64'(m_sh.size() < N && !m_pend && !m_swapping));
    check_output("swap_pending", 64'(swap_pending), 64'(m_pend));
`ifdef SYSARR_SAT_EN
    check_output("sat_flag", 64'(sat_flag), 64'(m_sat));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check at negedge.
  task automatic apply_stimulus(input bit rst, input bit iv, input logic [7:0] id, input bit wv,
                                input logic [7:0] wd, input bit sw, input logic [N*AW-1:0] si);
    reset = rst; in_valid = iv; in_data = id;
    w_wr_valid = wv; w_wr_data = wd; w_swap = sw; sum_in = si;
    model_edge(rst, iv, id, wv, wd, sw, si);
    @(negedge clock);
    compare_all();
  endtask

  function automatic logic [N*AW-1:0] fill(input logic [31:0] v);
    return {N{v}};
  endfunction

  task automatic idle(input logic [N*AW-1:0] si);
    apply_stimulus(0, 0, 8'h00, 0, 8'h00, 0, si);
  endtask

  task automatic load_word(input logic [7:0] w);
    apply_stimulus(0, 0, 8'h00, 1, w, 0, fill(32'd0));
  endtask

  task automatic token(input logic [7:0] d, input logic [N*AW-1:0] si);
    apply_stimulus(0, 1, d, 0, 8'h00, 0, si);
  endtask

  task automatic swap_pulse();
    apply_stimulus(0, 0, 8'h00, 0, 8'h00, 1, fill(32'd0));
  endtask

  initial begin
    logic [7:0] words [6];
    bit iv, wv, sw, rst;
    reset = 1; in_valid = 0; in_data = '0; sum_in = '0;
    w_wr_valid = 0; w_wr_data = '0; w_swap = 0;
    model_reset();
    @(negedge clock);

    // Reset state
    apply_stimulus(1, 0, 0, 0, 0, 0, fill(0));
    apply_stimulus(1, 0, 0, 0, 0, 0, fill(0));
    check_output("rst_weights_valid", 64'(weights_valid), 64'd0);
    check_output("rst_ready", 64'(w_wr_ready), 64'd1);
    check_output("rst_macc_valid", 64'(macc_valid), 64'd0);

    // Drop before any weights loaded
    token(8'd7, fill(0));
    check_output("drop_err_set", 64'(drop_err), 64'd1);
    check_output("drop_no_valid", 64'(macc_valid), 64'd0);
    repeat (3) idle(fill(0));
    check_output("drop_err_held", 64'(drop_err), 64'd1);

    // Load 1..4 with two extra words held under backpressure, then swap while idle
    apply_stimulus(1, 0, 0, 0, 0, 0, fill(0));
    words = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd9};
    for (int i = 0; i < 6; i++) load_word(words[i]);
    check_output("bp_ready_low", 64'(w_wr_ready), 64'd0);
    swap_pulse();
    check_output("wv_swap_cycle", 64'(weights_valid), 64'd0);
    idle(fill(0));
    check_output("wv_after_swap", 64'(weights_valid), 64'd1);

    token(8'd5, fill(32'd10));
    check_output("pe0_15", 64'(macc_out[0*AW +: AW]), 64'd15);
    idle(fill(32'd10));
    check_output("pe1_20", 64'(macc_out[1*AW +: AW]), 64'd20);
    idle(fill(32'd10));
    check_output("pe2_25", 64'(macc_out[2*AW +: AW]), 64'd25);
    idle(fill(32'd10));
    check_output("pe3_30", 64'(macc_out[3*AW +: AW]), 64'd30);
    check_output("dout_5", 64'(data_out), 64'd5);
    check_output("dout_valid", 64'(data_out_valid), 64'd1);
    idle(fill(0));

    // Deferred swap with a token in flight
    repeat (4) load_word(8'd2);
    token(8'd3, fill(32'd100));
    idle(fill(32'd100));
    apply_stimulus(0, 0, 0, 0, 0, 1, fill(32'd100));
    check_output("pending_set", 64'(swap_pending), 64'd1);
    idle(fill(32'd100));
    check_output("old_w_pe3", 64'(macc_out[3*AW +: AW]), 64'd112);
    check_output("pending_hold", 64'(swap_pending), 64'd1);
    idle(fill(32'd100));
    idle(fill(32'd100));
    check_output("pending_clr", 64'(swap_pending), 64'd0);
    idle(fill(32'd100));
    token(8'd6, fill(32'd100));
    check_output("new_w_pe0", 64'(macc_out[0*AW +: AW]), 64'd112);

    // Boundary arithmetic: -128 * -128 + 0x7FFF_FFFF
    repeat (4) load_word(8'h80);
    swap_pulse();
    idle(fill(0));
    idle(fill(0));
    token(8'h80, {96'd0, 32'h7FFF_FFFF});
`ifdef SYSARR_SAT_EN
    check_output("boundary_sat", 64'(macc_out[0 +: AW]), 64'h7FFF_FFFF);
    check_output("sat_flag_set", 64'(sat_flag), 64'd1);
`else
    check_output("boundary_wrap", 64'(macc_out[0 +: AW]), 64'h8000_3FFF);
`endif
    repeat (4) idle(fill(0));

    // Reset mid-load, then a fresh load must start at PE0
    apply_stimulus(1, 0, 0, 0, 0, 0, fill(0));
    load_word(8'd9);
    load_word(8'd9);
    apply_stimulus(1, 0, 0, 0, 0, 0, fill(0));
    check_output("midload_ready", 64'(w_wr_ready), 64'd1);
    check_output("midload_wv", 64'(weights_valid), 64'd0);
    for (int i = 0; i < 4; i++) load_word(8'(i + 1));
    swap_pulse();
    idle(fill(0));
    idle(fill(0));
    token(8'd7, fill(0));
    check_output("reload_pe0", 64'(macc_out[0 +: AW]), 64'd7);
    idle(fill(0));
    check_output("reload_pe1", 64'(macc_out[1*AW +: AW]), 64'd14);

    // Random traffic; input is stalled whenever a swap is pending or in progress
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      iv  = !m_pend && !m_swapping && ($urandom_range(0, 1) == 1);
      wv  = ($urandom_range(0, 1) == 1);
      sw  = ($urandom_range(0, 9) == 0);
      apply_stimulus(rst, iv, 8'($urandom), wv, 8'($urandom), sw,
                     {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
